// File: rtl/score_pkg.sv
// Shared encodings for the ping-pong referee: FSM states, winner/advantage codes, score width.
package score_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DEUCE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [1:0] ADV_NONE = 2'b00;
    localparam logic [1:0] ADV_P1   = 2'b01;
    localparam logic [1:0] ADV_P2   = 2'b10;

endpackage

// File: rtl/score_keeper_if.sv
// Referee bus: rally/new-game levels in, scores and match status out; server added under SCORE_SERVER_EN.
interface score_keeper_if;
    import score_pkg::*;

    logic               point_p1;
    logic               point_p2;
    logic               new_game;
    logic [SCORE_W-1:0] cnt1;
    logic [SCORE_W-1:0] cnt2;
    logic [1:0]         adv;
    logic               game_over;
    logic [1:0]         winner;
    logic               point_ack;
`ifdef SCORE_SERVER_EN
    logic               server;

    modport master (
        output point_p1, point_p2, new_game,
        input  cnt1, cnt2, adv, game_over, winner, point_ack, server
    );
    modport slave (
        input  point_p1, point_p2, new_game,
        output cnt1, cnt2, adv, game_over, winner, point_ack, server
    );
`else
    modport master (
        output point_p1, point_p2, new_game,
        input  cnt1, cnt2, adv, game_over, winner, point_ack
    );
    modport slave (
        input  point_p1, point_p2, new_game,
        output cnt1, cnt2, adv, game_over, winner, point_ack
    );
`endif

endinterface

// File: rtl/score_keeper_point_filter.sv
// Glitch filter: one-cycle evt on the cycle level completes HOLD_CYC consecutive high cycles.
// Latency 0 from the qualifying cycle (combinational evt); no backpressure, re-arms only after level drops.
module point_filter #(
    parameter int HOLD_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic evt
);
    localparam int          HOLD_W   = 8;
    localparam [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
    localparam [HOLD_W-1:0] HOLD_LST = HOLD_W'(HOLD_CYC - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturating at HOLD_CYC keeps evt from re-firing while the level stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (!level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign evt = level && (hold_cnt == HOLD_LST);

endmodule

// File: rtl/score_keeper.sv
// Ping-pong referee: filtered rally events -> 4-bit scores, deuce/advantage, winner; SCORE_SERVER_EN adds server.
// Latency 1 cycle from qualified event to score/point_ack; no backpressure, events outside PLAY/DEUCE are dropped.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE = 7,
    parameter int HOLD_CYC  = 1
) (
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave bus
);
    localparam logic [SCORE_W-1:0] WIN_Q  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);

    state_t             state;
    logic [SCORE_W-1:0] cnt1_q, cnt2_q;
    logic [1:0]         adv_q, win_q;
    logic               over_q, ack_q, ng_prev;
    logic               ev1, ev2, one_ev, ng_edge;
    logic [SCORE_W-1:0] nxt1, nxt2;
    logic [1:0]         mine;
`ifdef SCORE_SERVER_EN
    logic               server_q;
    logic [SCORE_W:0]   total_nxt;
`endif

    point_filter #(.HOLD_CYC(HOLD_CYC)) u_filt_p1 (
        .clk(clk), .rst(rst), .level(bus.point_p1), .evt(ev1)
    );
    point_filter #(.HOLD_CYC(HOLD_CYC)) u_filt_p2 (
        .clk(clk), .rst(rst), .level(bus.point_p2), .evt(ev2)
    );

    // Same-cycle events from both players cancel each other.
    assign one_ev  = ev1 ^ ev2;
    assign ng_edge = bus.new_game && !ng_prev;
    assign nxt1    = ev1 ? cnt1_q + 1'b1 : cnt1_q;
    assign nxt2    = ev2 ? cnt2_q + 1'b1 : cnt2_q;
    assign mine    = ev1 ? ADV_P1 : ADV_P2;
`ifdef SCORE_SERVER_EN
    assign total_nxt = {1'b0, cnt1_q} + {1'b0, cnt2_q} + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            adv_q   <= ADV_NONE;
            win_q   <= WIN_NONE;
            over_q  <= 1'b0;
            ack_q   <= 1'b0;
            ng_prev <= 1'b0;
`ifdef SCORE_SERVER_EN
            server_q <= 1'b0;
`endif
        end else begin
            ng_prev <= bus.new_game;
            ack_q   <= 1'b0;
            if (ng_edge) begin
                // Restart wins over any point qualifying in the same cycle.
                state  <= ST_PLAY;
                cnt1_q <= '0;
                cnt2_q <= '0;
                adv_q  <= ADV_NONE;
                win_q  <= WIN_NONE;
                over_q <= 1'b0;
`ifdef SCORE_SERVER_EN
                server_q <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (one_ev) begin
                            ack_q  <= 1'b1;
                            cnt1_q <= nxt1;
                            cnt2_q <= nxt2;
`ifdef SCORE_SERVER_EN
                            if (!total_nxt[0]) server_q <= ~server_q;
`endif
                            if (nxt1 == WIN_M1 && nxt2 == WIN_M1) begin
                                state <= ST_DEUCE;
                                adv_q <= ADV_NONE;
                            end else if (nxt1 == WIN_Q || nxt2 == WIN_Q) begin
                                state  <= ST_OVER;
                                over_q <= 1'b1;
                                win_q  <= ev1 ? WIN_P1 : WIN_P2;
                            end
                        end
                    end
                    ST_DEUCE: begin
                        if (one_ev) begin
                            ack_q <= 1'b1;
`ifdef SCORE_SERVER_EN
                            server_q <= ~server_q;
`endif
                            if (adv_q == ADV_NONE) begin
                                adv_q <= mine;
                            end else if (adv_q == mine) begin
                                state  <= ST_OVER;
                                over_q <= 1'b1;
                                adv_q  <= ADV_NONE;
                                win_q  <= ev1 ? WIN_P1 : WIN_P2;
                                if (ev1) cnt1_q <= WIN_Q;
                                else     cnt2_q <= WIN_Q;
                            end else begin
                                adv_q <= ADV_NONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cnt1      = cnt1_q;
    assign bus.cnt2      = cnt2_q;
    assign bus.adv       = adv_q;
    assign bus.game_over = over_q;
    assign bus.winner    = win_q;
    assign bus.point_ack = ack_q;
`ifdef SCORE_SERVER_EN
    assign bus.server    = server_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (WIN_SCORE=7, HOLD_CYC=4): expected results queued at stimulus, popped on point_ack.
module tb_score_keeper;
    import score_pkg::*;

    typedef struct packed {
        logic [3:0] c1;
        logic [3:0] c2;
        logic [1:0] adv;
        logic       go;
        logic [1:0] win;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    score_keeper_if bus();
    score_keeper #(.WIN_SCORE(7), .HOLD_CYC(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   ack_cnt = 0;
    int   n_push  = 0;
    int   ack0;

    function automatic exp_t mk(int c1, int c2, logic [1:0] adv, logic go, logic [1:0] win);
        exp_t e;
        e.c1  = 4'(c1);
        e.c2  = 4'(c2);
        e.adv = adv;
        e.go  = go;
        e.win = win;
        return e;
    endfunction

    function automatic exp_t cur();
        exp_t e;
        e.c1  = bus.cnt1;
        e.c2  = bus.cnt2;
        e.adv = bus.adv;
        e.go  = bus.game_over;
        e.win = bus.winner;
        return e;
    endfunction

    // Monitor: every point_ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.point_ack === 1'b1) begin
            exp_t e;
            exp_t g;
            ack_cnt++;
            n_cmp++;
            g = cur();
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack with cnt1=%0d cnt2=%0d adv=%b, required no ack",
                         g.c1, g.c2, g.adv);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL ack_%0d: got c1=%0d c2=%0d adv=%b go=%b win=%b, required c1=%0d c2=%0d adv=%b go=%b win=%b",
                             ack_cnt, g.c1, g.c2, g.adv, g.go, g.win, e.c1, e.c2, e.adv, e.go, e.win);
                end
            end
        end
    end

    task automatic check(input string name, input exp_t e);
        exp_t g;
        g = cur();
        n_cmp++;
        if ({g, bus.point_ack} !== {e, 1'b0}) begin
            n_err++;
            $display("FAIL %s: got c1=%0d c2=%0d adv=%b go=%b win=%b ack=%b, required c1=%0d c2=%0d adv=%b go=%b win=%b ack=0",
                     name, g.c1, g.c2, g.adv, g.go, g.win, bus.point_ack, e.c1, e.c2, e.adv, e.go, e.win);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p1, input logic p2, input int n);
        bus.point_p1 = p1;
        bus.point_p2 = p2;
        tick(n);
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
        tick(3);
    endtask

    task automatic score(input int who, input int n, input exp_t e);
        exp_q.push_back(e);
        n_push++;
        pulse(who == 1, who == 2, n);
    endtask

    task automatic new_game();
        bus.new_game = 1'b1;
        tick(2);
        bus.new_game = 1'b0;
        tick(2);
    endtask

    // new_game edge lands in the very cycle the P1 filter qualifies.
    task automatic ng_with_point();
        bus.point_p1 = 1'b1;
        tick(3);
        bus.new_game = 1'b1;
        tick(1);
        bus.point_p1 = 1'b0;
        bus.new_game = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        bus.point_p1 = 1'b0;
        bus.point_p2 = 1'b0;
        bus.new_game = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #5 check("reset_state", mk(0, 0, ADV_NONE, 0, WIN_NONE));
        @(posedge clk);
        #5 rst = 1'b1;
        tick(1);

        // Points in IDLE are ignored.
        pulse(1, 0, 5);
        check("idle_ignores", mk(0, 0, ADV_NONE, 0, WIN_NONE));

        // Reset mid-rally with point_p1 still high across release.
        new_game();
        for (int i = 1; i <= 3; i++) score(1, 5, mk(i, 0, ADV_NONE, 0, WIN_NONE));
        check("pre_reset", mk(3, 0, ADV_NONE, 0, WIN_NONE));
        bus.point_p1 = 1'b1;
        tick(2);
        #3 rst = 1'b0;
        #2 check("reset_mid_rally", mk(0, 0, ADV_NONE, 0, WIN_NONE));
        @(posedge clk);
        #5 rst = 1'b1;
        tick(8);
        check("post_reset_held", mk(0, 0, ADV_NONE, 0, WIN_NONE));
        bus.point_p1 = 1'b0;
        tick(2);

        // Straight win for P1.
        new_game();
        ack0 = ack_cnt;
        for (int i = 1; i <= 7; i++)
            score(1, 5, mk(i, 0, ADV_NONE, i == 7, (i == 7) ? WIN_P1 : WIN_NONE));
        check("p1_win", mk(7, 0, ADV_NONE, 1, WIN_P1));
        n_cmp++;
        if (ack_cnt - ack0 != 7) begin
            n_err++;
            $display("FAIL p1_win_acks: got %0d acks, required 7", ack_cnt - ack0);
        end

        // OVER holds; restart with a same-cycle point clears everything.
        pulse(0, 1, 5);
        check("over_hold", mk(7, 0, ADV_NONE, 1, WIN_P1));
        ng_with_point();
        check("over_restart", mk(0, 0, ADV_NONE, 0, WIN_NONE));

        // Restart priority in PLAY.
        score(1, 5, mk(1, 0, ADV_NONE, 0, WIN_NONE));
        ng_with_point();
        check("play_restart", mk(0, 0, ADV_NONE, 0, WIN_NONE));

        // Simultaneous qualification cancels.
        pulse(1, 1, 5);
        check("simultaneous", mk(0, 0, ADV_NONE, 0, WIN_NONE));

        // Glitch filter: 3 cycles ignored, 10 cycles counts once.
        pulse(1, 0, 3);
        check("short_pulse", mk(0, 0, ADV_NONE, 0, WIN_NONE));
        score(1, 10, mk(1, 0, ADV_NONE, 0, WIN_NONE));
        check("long_pulse", mk(1, 0, ADV_NONE, 0, WIN_NONE));

        // Climb to 6:6, then P1, P2, P2, P2 through deuce.
        score(2, 5, mk(1, 1, ADV_NONE, 0, WIN_NONE));
        for (int k = 2; k <= 6; k++) begin
            score(1, 5, mk(k, k - 1, ADV_NONE, 0, WIN_NONE));
            score(2, 5, mk(k, k, ADV_NONE, 0, WIN_NONE));
        end
        score(1, 5, mk(6, 6, ADV_P1, 0, WIN_NONE));
        score(2, 5, mk(6, 6, ADV_NONE, 0, WIN_NONE));
        score(2, 5, mk(6, 6, ADV_P2, 0, WIN_NONE));
        score(2, 5, mk(6, 7, ADV_NONE, 1, WIN_P2));
        check("deuce_final", mk(6, 7, ADV_NONE, 1, WIN_P2));

        tick(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_acks: got %0d expectations unmatched, required 0", exp_q.size());
        end
        n_cmp++;
        if (ack_cnt != n_push) begin
            n_err++;
            $display("FAIL total_acks: got %0d acks, required %0d", ack_cnt, n_push);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
